// File: rtl/bomber_stats_encoder.sv
// bomber_stats_encoder: converts a player stats sample (tile X/Y, lives, bombs)
// into the packed tens/units word read by the text overlay stage.
// Optional feature: define BOMBER_STATS_VBLNK_SYNC_EN to hold each commit
// until the next rising edge of i_vblnk, so the overlay never tears mid-frame.
module bomber_stats_encoder #(
    parameter int unsigned POS_MAX = 19
) (
    input  logic        i_pclk,
    input  logic        i_rst_n,
    input  logic        i_vblnk,
    input  logic        i_stats_valid,
    output logic        o_stats_ready,
    input  logic [4:0]  i_pos_x,
    input  logic [4:0]  i_pos_y,
    input  logic [2:0]  i_lives,
    input  logic [1:0]  i_bombs,
    output logic [14:0] o_axi_data,
    output logic        o_update,
    output logic        o_range_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONV_X     = 3'd1,
        CONV_Y     = 3'd2,
`ifdef BOMBER_STATS_VBLNK_SYNC_EN
        WAIT_FRAME = 3'd3,
`endif
        COMMIT     = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] bombs;
        logic [2:0] lives;
        logic [4:0] y;
        logic [4:0] x;
    } stats_t;

    localparam logic [4:0] POS_MAX_C = 5'(POS_MAX);

    // Clamp a coordinate to POS_MAX and split it into {units[3:0], tens}.
    function automatic logic [4:0] enc_coord(input logic [4:0] v);
        logic [4:0] c;
        logic [4:0] d;
        c = (v > POS_MAX_C) ? POS_MAX_C : v;
        d = c - 5'd10;
        if (c >= 5'd10) enc_coord = {d[3:0], 1'b1};
        else            enc_coord = {c[3:0], 1'b0};
    endfunction

    state_t      state, state_nxt;
    stats_t      work;
    logic [14:0] shadow;
    logic        vblnk_rise;

`ifdef BOMBER_STATS_VBLNK_SYNC_EN
    logic vblnk_q;

    // Registered copy of vblnk for rising-edge detection.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) vblnk_q <= 1'b0;
        else          vblnk_q <= i_vblnk;
    end

    assign vblnk_rise = i_vblnk & ~vblnk_q;
`else
    logic unused_vblnk;
    assign unused_vblnk = i_vblnk;
    assign vblnk_rise   = 1'b0;
`endif

    assign o_stats_ready = (state == IDLE);

    // State register.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; vblnk edges only matter while waiting for the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (i_stats_valid) state_nxt = CONV_X;
            CONV_X:     state_nxt = CONV_Y;
`ifdef BOMBER_STATS_VBLNK_SYNC_EN
            CONV_Y:     state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (vblnk_rise) state_nxt = COMMIT;
`else
            CONV_Y:     state_nxt = COMMIT;
`endif
            COMMIT:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Capture, per-coordinate conversion into the shadow word, and commit.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work        <= '0;
            shadow      <= '0;
            o_axi_data  <= '0;
            o_update    <= 1'b0;
            o_range_err <= 1'b0;
        end else begin
            o_update <= 1'b0;
            case (state)
                IDLE: if (i_stats_valid) work <= {i_bombs, i_lives, i_pos_y, i_pos_x};
                CONV_X: begin
                    shadow[4:0]   <= enc_coord(work.x);
                    shadow[14:10] <= {work.bombs, work.lives};
                    if (work.x > POS_MAX_C) o_range_err <= 1'b1;
                end
                CONV_Y: begin
                    shadow[9:5] <= enc_coord(work.y);
                    if (work.y > POS_MAX_C) o_range_err <= 1'b1;
                end
                COMMIT: begin
                    o_axi_data <= shadow;
                    o_update   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bomber_stats_encoder.sv
// Bench for bomber_stats_encoder: decimal-arithmetic reference model compared
// every cycle, plus literal expectations for the listed scenarios.
module tb_bomber_stats_encoder;

    localparam int PM = 19;
`ifdef BOMBER_STATS_VBLNK_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vblnk;
    logic        valid;
    logic        ready;
    logic [4:0]  px, py;
    logic [2:0]  lv;
    logic [1:0]  bm;
    logic [14:0] data;
    logic        upd;
    logic        rerr;

    int checks = 0;
    int fails  = 0;
    logic chk_on = 1'b0;

    logic       vb_auto = 1'b0;
    logic       vb_man  = 1'b0;
    logic       vb_auto_v = 1'b0;
    logic [4:0] vb_cnt = '0;

    bomber_stats_encoder #(.POS_MAX(PM)) dut (
        .i_pclk(clk), .i_rst_n(rst_n), .i_vblnk(vblnk),
        .i_stats_valid(valid), .o_stats_ready(ready),
        .i_pos_x(px), .i_pos_y(py), .i_lives(lv), .i_bombs(bm),
        .o_axi_data(data), .o_update(upd), .o_range_err(rerr)
    );

    always #5 clk = ~clk;

    // free-running vblnk pattern: high 4 of every 32 cycles
    always @(negedge clk) begin
        vb_cnt    <= vb_cnt + 5'd1;
        vb_auto_v <= (vb_cnt[4:2] == 3'd0);
    end
    assign vblnk = vb_auto ? vb_auto_v : vb_man;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // expected word from decimal digits of the clamped coordinates
    function automatic logic [14:0] exp_word(int x, int y, int l, int b);
        int cx, cy;
        cx = (x > PM) ? PM : x;
        cy = (y > PM) ? PM : y;
        return 15'(b * 8192 + l * 1024 + (cy % 10) * 64 + (cy / 10) * 32
                   + (cx % 10) * 2 + cx / 10);
    endfunction

    // model: busy 0 idle, 3/2 converting x/y, 4 waiting for frame, 1 committing
    logic [2:0]  m_busy;
    logic [14:0] m_data, m_pend;
    logic        m_upd, m_err, m_xe, m_ye, m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 3'd0; m_data <= '0; m_pend <= '0; m_upd <= 1'b0;
            m_err <= 1'b0; m_xe <= 1'b0; m_ye <= 1'b0; m_prev <= 1'b0;
        end else begin
            m_upd  <= 1'b0;
            m_prev <= vblnk;
            case (m_busy)
                3'd0: if (valid) begin
                    m_busy <= 3'd3;
                    m_pend <= exp_word(int'(px), int'(py), int'(lv), int'(bm));
                    m_xe   <= int'(px) > PM;
                    m_ye   <= int'(py) > PM;
                end
                3'd3: begin m_busy <= 3'd2; if (m_xe) m_err <= 1'b1; end
                3'd2: begin m_busy <= SYNC ? 3'd4 : 3'd1; if (m_ye) m_err <= 1'b1; end
                3'd4: if (vblnk && !m_prev) m_busy <= 3'd1;
                default: begin m_busy <= 3'd0; m_data <= m_pend; m_upd <= 1'b1; end
            endcase
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_data",  32'(data),  32'(m_data));
            chk("cyc_update", 32'(upd),  32'(m_upd));
            chk("cyc_ready", 32'(ready), 32'(m_busy == 3'd0));
            chk("cyc_rerr",  32'(rerr),  32'(m_err));
        end
    end

    task automatic send(input int x, input int y, input int l, input int b);
        @(negedge clk);
        valid = 1'b1; px = 5'(x); py = 5'(y); lv = 3'(l); bm = 2'(b);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_update(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!upd && n < 1000);
        if (!upd) chk("wait_update_timeout", 32'(upd), 32'd1);
    endtask

    int n, cnt;

    initial begin
        rst_n = 1'b1; valid = 1'b0; px = '0; py = '0; lv = '0; bm = '0;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_update", 32'(upd), 32'd0);
        chk("rst_rerr", 32'(rerr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_first", 32'(ready), 32'd1);
        vb_auto = SYNC;

        send(7, 13, 3, 2);
        wait_update(n);
        if (!SYNC) chk("latency", 32'(n), 32'd3);
        chk("w_7_13", 32'(data), 32'(15'b10_011_0011_1_0111_0));
        chk("rerr_legal", 32'(rerr), 32'd0);
        @(negedge clk);
        chk("update_one_cycle", 32'(upd), 32'd0);

        send(10, 9, 5, 1);
        wait_update(n);
        chk("w_10_9", 32'(data), 32'(15'b01_101_1001_0_0000_1));

        send(19, 19, 0, 0);
        wait_update(n);
        chk("w_19_19", 32'(data), 32'(15'b00_000_1001_1_1001_1));
        chk("rerr_at_max", 32'(rerr), 32'd0);

        send(25, 19, 7, 3);
        wait_update(n);
        chk("w_25_19", 32'(data), 32'(15'b11_111_1001_1_1001_1));
        chk("rerr_set", 32'(rerr), 32'd1);

        send(4, 0, 0, 0);
        wait_update(n);
        chk("w_4_0", 32'(data), 32'(15'b00_000_0000_0_0100_0));
        chk("rerr_sticky", 32'(rerr), 32'd1);

        // reset while converting abandons the sample
        send(3, 4, 1, 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rstconv_data", 32'(data), 32'd0);
        chk("rstconv_rerr", 32'(rerr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstconv_ready", 32'(ready), 32'd1);
        cnt = 0;
        repeat (40) begin @(negedge clk); if (upd) cnt++; end
        chk("rstconv_no_update", 32'(cnt), 32'd0);

        // valid held high with data changing every cycle
        @(negedge clk);
        valid = 1'b1;
        repeat (60) begin
            px = 5'($urandom_range(0, 31)); py = 5'($urandom_range(0, 31));
            lv = 3'($urandom_range(0, 7));  bm = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        valid = 1'b0;
        repeat (40) @(negedge clk);

`ifdef BOMBER_STATS_VBLNK_SYNC_EN
        vb_auto = 1'b0; vb_man = 1'b0;
        repeat (3) @(negedge clk);
        send(1, 2, 3, 1);
        repeat (200) @(negedge clk);
        chk("wait_ready_low", 32'(ready), 32'd0);
        chk("wait_data_held", 32'(data), 32'(m_data));
        vb_man = 1'b1;
        wait_update(n);
        chk("vb_commit_lat", 32'(n), 32'd2);
        chk("w_1_2", 32'(data), 32'(15'b01_011_0010_0_0001_0));
        @(negedge clk);
        chk("vb_update_one", 32'(upd), 32'd0);

        // vblnk already high on entry: needs a fresh rising edge
        send(11, 5, 2, 2);
        repeat (20) @(negedge clk);
        chk("vbhigh_no_commit", 32'(ready), 32'd0);
        vb_man = 1'b0;
        repeat (3) @(negedge clk);
        vb_man = 1'b1;
        wait_update(n);
        chk("vbhigh_lat", 32'(n), 32'd2);
        chk("w_11_5", 32'(data), 32'(15'b10_010_0101_0_0001_1));

        // reset while waiting for the frame
        vb_man = 1'b0;
        send(9, 9, 1, 1);
        repeat (6) @(negedge clk);
        chk("inwait_ready", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rstwait_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstwait_ready", 32'(ready), 32'd1);
        vb_man = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (upd) cnt++; end
        chk("rstwait_no_update", 32'(cnt), 32'd0);
`endif

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bomber_stats_encoder.md
BOMBER_STATS_ENCODER -- requirements
Module: bomber_stats_encoder

Interface
REQ-001 Parameter POS_MAX, default 19, is the largest legal position coordinate; the SHALL-range is 10..19 because the tens digit is 1 bit.
REQ-002 i_pclk  input  1  pixel clock; the only clock.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_vblnk  input  1  vertical blanking from the timing chain, synchronous to i_pclk.
REQ-005 i_stats_valid  input  1  a new stats sample is offered.
REQ-006 o_stats_ready  output  1  the encoder accepts a sample; high only in IDLE.
REQ-007 i_pos_x  input  5  player X tile coordinate, binary.
REQ-008 i_pos_y  input  5  player Y tile coordinate, binary.
REQ-009 i_lives  input  3  remaining lives.
REQ-010 i_bombs  input  2  available bombs.
REQ-011 o_axi_data  output  15  packed stats word for the text overlay stage: [0]=X tens, [4:1]=X units, [5]=Y tens, [9:6]=Y units, [12:10]=lives, [14:13]=bombs.
REQ-012 o_update  output  1  one-cycle pulse in the cycle o_axi_data takes a new value.
REQ-013 o_range_err  output  1  sticky flag: some accepted coordinate exceeded POS_MAX.

Function
REQ-014 The FSM SHALL have the states IDLE, CONV_X, CONV_Y, WAIT_FRAME and COMMIT, encoded in a registered state register.
REQ-015 IDLE: the handshake (i_stats_valid && o_stats_ready) at a clock edge SHALL capture all four stat inputs into working registers and move the FSM to CONV_X.
REQ-016 When i_stats_valid is low, IDLE SHALL hold; the inputs are don't-care.
REQ-017 CONV_X (one cycle): clamp x to POS_MAX if larger and set o_range_err. If the clamped x >= 10, X tens=1 and X units=x-10; otherwise X tens=0 and X units=x. Then go to CONV_Y.
REQ-018 CONV_Y (one cycle): the same rule applies to y. Then go to WAIT_FRAME, or to COMMIT when the frame sync is compiled out.
REQ-019 WAIT_FRAME SHALL hold until a rising edge of i_vblnk is detected, i.e. i_vblnk=1 while its registered copy is 0. It then goes to COMMIT.
REQ-020 COMMIT (one cycle) SHALL load the shadow word into o_axi_data, assert o_update, and return to IDLE.
REQ-021 o_axi_data SHALL change only in COMMIT; it is stable at all other times, including during conversion.
REQ-022 Latency without frame sync: a handshake at edge E0 SHALL update o_axi_data at edge E3, and o_stats_ready SHALL be high again from E3.
REQ-023 If a vblnk rising edge occurs while the FSM is not in WAIT_FRAME, the edge SHALL be ignored and not remembered.
REQ-024 A vblnk rising edge in the same cycle the FSM enters WAIT_FRAME SHALL not count; only edges detected while in WAIT_FRAME count.
REQ-025 Lives and bombs SHALL pass through unmodified; the full 3-bit and 2-bit ranges are legal.
REQ-026 o_range_err SHALL clear only on reset.

Reset
REQ-027 Assertion of i_rst_n=0 SHALL immediately force: state=IDLE, o_axi_data=0, o_update=0, o_range_err=0, all working, shadow and vblnk-edge registers=0.
REQ-028 Reset during any state SHALL abandon the pending sample without committing it.
REQ-029 After reset deassertion, o_stats_ready SHALL be 1 on the first clock.

Configuration
REQ-030 Macro BOMBER_STATS_VBLNK_SYNC_EN defined: WAIT_FRAME is present and commits are aligned to a vblnk rising edge, so there is no mid-frame tearing.
REQ-031 Macro undefined: WAIT_FRAME and the vblnk edge register are removed, i_vblnk is unused, and CONV_Y goes directly to COMMIT.

Verification
REQ-032 Sync off: x=7, y=13, lives=3, bombs=2 handshaked at E0 -> o_axi_data=15'b10_011_0011_1_0111_0, o_update at E3, o_range_err=0.
REQ-033 Sync off: x=25, y=19 -> X tens=1, X units=9, Y tens=1, Y units=9, o_range_err=1 and it stays 1 after a later legal sample.
REQ-034 Sync on: sample accepted mid-frame, vblnk rising 200 cycles later -> o_axi_data unchanged until that edge, o_update exactly one cycle, o_stats_ready low throughout the wait.
REQ-035 Sync on: vblnk already high at entry to WAIT_FRAME -> no commit until vblnk falls and rises again.
REQ-036 i_rst_n pulsed low while in WAIT_FRAME -> o_axi_data=0, o_update never pulses, and o_stats_ready=1 on the first edge after release.
REQ-037 i_stats_valid held high continuously with changing data -> samples are accepted only when o_stats_ready=1, and each committed word matches the data present at its handshake edge.
